// File: rtl/coin_pulse_ctrl_pkg.sv
// Shared types and width helpers for the coin pulse conditioner.
// Channel FSM states, default parameter values and counter-width functions.
package coin_pulse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_GAP   = 2'd2
    } ch_state_e;

    localparam int NCH_DEF         = 32'sd2;
    localparam int DEB_CYC_DEF     = 32'sd16;
    localparam int HOLD_FRAMES_DEF = 32'sd3;
    localparam int GAP_FRAMES_DEF  = 32'sd3;
    localparam int QMAX_DEF        = 32'sd3;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int width_for(input int n);
        return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
    endfunction

    function automatic int pend_width(input int qmax);
        return width_for(qmax + 32'sd1);
    endfunction

    function automatic int fcnt_width(input int hold, input int gap);
        return width_for((hold > gap) ? hold : gap);
    endfunction

    localparam int PEND_W_DEF = pend_width(QMAX_DEF);
    localparam int FCNT_W_DEF = fcnt_width(HOLD_FRAMES_DEF, GAP_FRAMES_DEF);

endpackage

// File: rtl/coin_pulse_ctrl_if.sv
// Coin conditioner bus: controls and raw buttons in, shaped pulses and status out.
interface coin_pulse_ctrl_if #(
    parameter int NCH = 2
);
    logic            enable;
    logic            vblank;
    logic [NCH-1:0]  coin_raw;
    logic [NCH-1:0]  coin_out;
    logic [NCH-1:0]  busy;
    logic            overflow;
    logic [15:0]     coin_total;

    modport master (
        output enable, vblank, coin_raw,
        input  coin_out, busy, overflow, coin_total
    );

    modport slave (
        input  enable, vblank, coin_raw,
        output coin_out, busy, overflow, coin_total
    );
endinterface

// File: rtl/coin_pulse_ctrl_channel.sv
// One coin channel: input register, debounce, saturating press queue and
// a frame-paced PULSE/GAP sequencer.
module coin_channel
    import coin_pulse_pkg::*;
#(
    parameter int DEB_CYC     = DEB_CYC_DEF,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
    parameter int GAP_FRAMES  = GAP_FRAMES_DEF,
    parameter int QMAX        = QMAX_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic tick,
    input  logic coin_raw,
    output logic coin_out,
    output logic busy,
    output logic start,
    output logic drop
);
    localparam int DEB_W  = width_for(DEB_CYC);
    localparam int PEND_W = pend_width(QMAX);
    localparam int FCNT_W = fcnt_width(HOLD_FRAMES, GAP_FRAMES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYC - 32'sd1);
    localparam logic [DEB_W-1:0]  DEB_ZERO  = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0]  DEB_ONE   = DEB_W'(32'sd1);
    localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(QMAX);
    localparam logic [PEND_W-1:0] PEND_ZERO = {PEND_W{1'b0}};
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(32'sd1);
    localparam logic [FCNT_W-1:0] HOLD_LOAD = FCNT_W'(HOLD_FRAMES - 32'sd1);
    localparam logic [FCNT_W-1:0] GAP_LOAD  = FCNT_W'(GAP_FRAMES - 32'sd1);
    localparam logic [FCNT_W-1:0] FCNT_ZERO = {FCNT_W{1'b0}};
    localparam logic [FCNT_W-1:0] FCNT_ONE  = FCNT_W'(32'sd1);

    logic              coin_q_r;
    logic              deb_lvl_r;
    logic [DEB_W-1:0]  deb_cnt_r;
    logic [PEND_W-1:0] pend_r;
    logic [FCNT_W-1:0] fcnt_r;
    ch_state_e         state_r;
    logic              coin_out_r;
    logic              busy_r;

    logic              deb_diff_s;
    logic              deb_done_s;
    logic              press_s;
    logic              start_s;
    logic              drop_s;
    ch_state_e         state_nxt_s;
    logic [FCNT_W-1:0] fcnt_nxt_s;
    logic [PEND_W-1:0] pend_nxt_s;

    // Next-state logic: press detection, queue accounting and frame sequencing.
    always_comb begin
        deb_diff_s  = coin_q_r ^ deb_lvl_r;
        deb_done_s  = deb_diff_s && (deb_cnt_r == DEB_LAST);
        press_s     = enable && deb_done_s && coin_q_r;
        start_s     = enable && tick && (state_r == ST_IDLE) && (pend_r != PEND_ZERO);
        drop_s      = press_s && !start_s && (pend_r == PEND_MAX);
        state_nxt_s = state_r;
        fcnt_nxt_s  = fcnt_r;
        pend_nxt_s  = pend_r;
        if (!enable) begin
            state_nxt_s = ST_IDLE;
            fcnt_nxt_s  = FCNT_ZERO;
            pend_nxt_s  = PEND_ZERO;
        end else begin
            // A press that meets a dequeue cancels out, even at a full queue.
            if (press_s && !start_s && (pend_r != PEND_MAX)) begin
                pend_nxt_s = pend_r + PEND_ONE;
            end else if (start_s && !press_s) begin
                pend_nxt_s = pend_r - PEND_ONE;
            end else begin
                pend_nxt_s = pend_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_nxt_s = ST_PULSE;
                        fcnt_nxt_s  = HOLD_LOAD;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PULSE: begin
                    if (tick && (fcnt_r == FCNT_ZERO)) begin
                        state_nxt_s = ST_GAP;
                        fcnt_nxt_s  = GAP_LOAD;
                    end else if (tick) begin
                        fcnt_nxt_s = fcnt_r - FCNT_ONE;
                    end else begin
                        fcnt_nxt_s = fcnt_r;
                    end
                end
                ST_GAP: begin
                    if (tick && (fcnt_r == FCNT_ZERO)) begin
                        state_nxt_s = ST_IDLE;
                    end else if (tick) begin
                        fcnt_nxt_s = fcnt_r - FCNT_ONE;
                    end else begin
                        fcnt_nxt_s = fcnt_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    fcnt_nxt_s  = FCNT_ZERO;
                end
            endcase
        end
    end

    // Input register and debounce; while disabled the level follows the input silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            coin_q_r  <= 1'b0;
            deb_lvl_r <= 1'b0;
            deb_cnt_r <= DEB_ZERO;
        end else begin
            coin_q_r <= coin_raw;
            if (!enable) begin
                deb_lvl_r <= coin_q_r;
                deb_cnt_r <= DEB_ZERO;
            end else if (!deb_diff_s) begin
                deb_cnt_r <= DEB_ZERO;
            end else if (deb_done_s) begin
                deb_lvl_r <= coin_q_r;
                deb_cnt_r <= DEB_ZERO;
            end else begin
                deb_cnt_r <= deb_cnt_r + DEB_ONE;
            end
        end
    end

    // Channel FSM state, queue depth and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            fcnt_r     <= FCNT_ZERO;
            pend_r     <= PEND_ZERO;
            coin_out_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            fcnt_r     <= fcnt_nxt_s;
            pend_r     <= pend_nxt_s;
            coin_out_r <= (state_nxt_s == ST_PULSE);
            busy_r     <= (state_nxt_s != ST_IDLE) || (pend_nxt_s != PEND_ZERO);
        end
    end

    assign coin_out = coin_out_r;
    assign busy     = busy_r;
    assign start    = start_s;
    assign drop     = drop_s;

endmodule

// File: rtl/coin_pulse_ctrl.sv
// Coin pulse conditioner top: frame tick detect, per-channel shapers,
// overflow flag and issued-coin counter.
module coin_pulse_ctrl
    import coin_pulse_pkg::*;
#(
    parameter int NCH         = NCH_DEF,
    parameter int DEB_CYC     = DEB_CYC_DEF,
    parameter int HOLD_FRAMES = HOLD_FRAMES_DEF,
    parameter int GAP_FRAMES  = GAP_FRAMES_DEF,
    parameter int QMAX        = QMAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    coin_pulse_ctrl_if.slave  bus
);
    logic           vblank_d_r;
    logic           overflow_r;
    logic [15:0]    coin_total_r;
    logic           tick_s;
    logic [NCH-1:0] coin_out_s;
    logic [NCH-1:0] busy_s;
    logic [NCH-1:0] start_s;
    logic [NCH-1:0] drop_s;

    function automatic logic [15:0] popcount(input logic [NCH-1:0] v);
        logic [15:0] s;
        s = 16'd0;
        for (int i = 0; i < NCH; i++) begin
            s = s + {15'd0, v[i]};
        end
        return s;
    endfunction

    assign tick_s = bus.vblank & ~vblank_d_r;

    generate
        for (genvar g = 0; g < NCH; g++) begin : g_ch
            coin_channel #(
                .DEB_CYC     (DEB_CYC),
                .HOLD_FRAMES (HOLD_FRAMES),
                .GAP_FRAMES  (GAP_FRAMES),
                .QMAX        (QMAX)
            ) u_ch (
                .clk      (clk),
                .reset    (reset),
                .enable   (bus.enable),
                .tick     (tick_s),
                .coin_raw (bus.coin_raw[g]),
                .coin_out (coin_out_s[g]),
                .busy     (busy_s[g]),
                .start    (start_s[g]),
                .drop     (drop_s[g])
            );
        end
    endgenerate

    // Frame edge history, overflow flag and wrapping coin counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            vblank_d_r   <= 1'b0;
            overflow_r   <= 1'b0;
            coin_total_r <= 16'd0;
        end else begin
            vblank_d_r   <= bus.vblank;
            overflow_r   <= |drop_s;
            coin_total_r <= coin_total_r + popcount(start_s);
        end
    end

    assign bus.coin_out   = coin_out_s;
    assign bus.busy       = busy_s;
    assign bus.overflow   = overflow_r;
    assign bus.coin_total = coin_total_r;

endmodule

// File: tb/tb_coin_pulse_ctrl.sv
// Self-checking bench for coin_pulse_ctrl: directed scenarios plus random
// button traffic, compared every cycle against a frame-count reference model.
module tb_coin_pulse_ctrl;
    localparam int NCH = 2, DEB = 16, HOLD = 3, GAP = 3, QMAX = 3, FRAME = 100;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0, failures = 0, ovf_seen = 0, fcnt_tb = 0;
    bit   vb_hold = 1'b0;

    coin_pulse_ctrl_if #(.NCH(NCH)) bus();
    coin_pulse_ctrl #(.NCH(NCH), .DEB_CYC(DEB), .HOLD_FRAMES(HOLD),
                      .GAP_FRAMES(GAP), .QMAX(QMAX)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: a channel is either idle or some number of ticks into its pulse+gap window.
    logic [NCH-1:0] m_q, m_lvl;
    int  m_run[NCH], m_pend[NCH], m_phase[NCH];
    bit  m_act[NCH];
    bit  m_vbd, m_ovf;
    int  m_total;

    always @(posedge clk) begin : model
        int  nstart;
        bit  tick, press, start, drop_any;
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                m_run[c] = 0; m_pend[c] = 0; m_phase[c] = 0; m_act[c] = 1'b0;
            end
            m_q = '0; m_lvl = '0; m_vbd = 1'b0; m_ovf = 1'b0; m_total = 0;
        end else begin
            tick = bus.vblank && !m_vbd;
            nstart = 0; drop_any = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                press = 1'b0; start = 1'b0;
                if (!bus.enable) begin
                    m_lvl[c] = m_q[c]; m_run[c] = 0; m_pend[c] = 0;
                    m_act[c] = 1'b0; m_phase[c] = 0;
                end else begin
                    if (m_q[c] != m_lvl[c]) begin
                        m_run[c]++;
                        if (m_run[c] == DEB) begin
                            m_lvl[c] = m_q[c]; m_run[c] = 0; press = m_q[c];
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                    if (tick) begin
                        if (!m_act[c]) begin
                            if (m_pend[c] > 0) begin
                                start = 1'b1; m_act[c] = 1'b1; m_phase[c] = 0; nstart++;
                            end
                        end else begin
                            m_phase[c]++;
                            if (m_phase[c] == HOLD + GAP) m_act[c] = 1'b0;
                        end
                    end
                    if (press && !start && m_pend[c] == QMAX) drop_any = 1'b1;
                    else m_pend[c] = m_pend[c] - int'(start) + int'(press);
                end
            end
            m_q = bus.coin_raw; m_vbd = bus.vblank;
            m_total = (m_total + nstart) % 65536;
            m_ovf = drop_any;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock per iteration: compare against the model, then drive vblank.
    task automatic step(input int n);
        logic [NCH-1:0] eo, eb;
        repeat (n) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) begin
                eo[c] = m_act[c] && (m_phase[c] < HOLD);
                eb[c] = m_act[c] || (m_pend[c] != 0);
            end
            chk("cyc_coin_out", 32'(bus.coin_out), 32'(eo));
            chk("cyc_busy", 32'(bus.busy), 32'(eb));
            chk("cyc_overflow", 32'(bus.overflow), 32'(m_ovf));
            chk("cyc_coin_total", 32'(bus.coin_total), 32'(m_total));
            if (bus.overflow === 1'b1) ovf_seen++;
            fcnt_tb = (fcnt_tb + 1) % FRAME;
            bus.vblank = vb_hold || (fcnt_tb >= FRAME - 10);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.coin_raw = '0; bus.enable = 1'b1; vb_hold = 1'b0;
        step(2);
        chk("rst_coin_out", 32'(bus.coin_out), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_total", 32'(bus.coin_total), 32'd0);
        reset = 1'b0;
    endtask

    task automatic press(input int ch, input int hi, input int lo);
        bus.coin_raw[ch] = 1'b1; step(hi);
        bus.coin_raw[ch] = 1'b0; step(lo);
    endtask

    task automatic wait_level(input int ch, input logic lvl, input int budget, input string name);
        int n = 0;
        while (bus.coin_out[ch] !== lvl && n < budget) begin step(1); n++; end
        chk(name, 32'(bus.coin_out[ch]), 32'(lvl));
    endtask

    task automatic run_len(input int ch, input logic lvl, input int budget, output int n);
        n = 0;
        while (bus.coin_out[ch] === lvl && n < budget) begin step(1); n++; end
    endtask

    initial begin : main
        int n, prev_total, base_ovf, hold_left[NCH], en_left, vh_left;
        bit any_hi;
        reset = 1'b1; bus.enable = 1'b1; bus.vblank = 1'b0; bus.coin_raw = '0;

        // Single press
        do_reset();
        press(0, 40, 1);
        wait_level(0, 1'b1, 400, "t1_rise");
        run_len(0, 1'b1, 2000, n);
        chk("t1_high_cycles", 32'(n), 32'd300);
        chk("t1_total", 32'(bus.coin_total), 32'd1);
        chk("t1_model_total", 32'(m_total), 32'd1);
        n = 0;
        while (bus.busy[0] === 1'b1 && n < 2000) begin step(1); n++; end
        chk("t1_busy_tail", 32'(n), 32'd300);

        // Glitch shorter than the debounce window
        do_reset();
        press(0, 10, 1);
        any_hi = 1'b0;
        repeat (400) begin step(1); if (bus.coin_out != '0 || bus.busy != '0) any_hi = 1'b1; end
        chk("t2_no_activity", 32'(any_hi), 32'd0);
        chk("t2_total", 32'(bus.coin_total), 32'd0);

        // Queue saturation while frames are stalled
        do_reset();
        vb_hold = 1'b1; base_ovf = ovf_seen;
        repeat (5) press(0, 20, 20);
        chk("t3_overflow_pulses", 32'(ovf_seen - base_ovf), 32'd2);
        chk("t3_model_pend", 32'(m_pend[0]), 32'd3);
        chk("t3_busy", 32'(bus.busy[0]), 32'd1);
        vb_hold = 1'b0;
        for (int p = 0; p < 3; p++) begin
            wait_level(0, 1'b1, 600, "t3_rise");
            run_len(0, 1'b1, 2000, n);
            chk("t3_high_cycles", 32'(n), 32'd300);
            run_len(0, 1'b0, 1000, n);
            chk("t3_low_cycles", 32'(n), (p < 2) ? 32'd400 : 32'd1000);
        end
        chk("t3_total", 32'(bus.coin_total), 32'd3);

        // Simultaneous channels
        do_reset();
        bus.coin_raw = 2'b11; step(40); bus.coin_raw = 2'b00;
        n = 0; prev_total = bus.coin_total;
        while (bus.coin_out === 2'b00 && n < 400) begin prev_total = bus.coin_total; step(1); n++; end
        chk("t4_both_rise", 32'(bus.coin_out), 32'd3);
        chk("t4_total_before", 32'(prev_total), 32'd0);
        chk("t4_total_after", 32'(bus.coin_total), 32'd2);

        // Enable drop mid-pulse with a held button
        do_reset();
        vb_hold = 1'b1;
        repeat (3) press(0, 20, 20);
        vb_hold = 1'b0;
        wait_level(0, 1'b1, 600, "t5_rise");
        step(50);
        chk("t5_model_pend", 32'(m_pend[0]), 32'd2);
        bus.coin_raw[0] = 1'b1; step(1);
        bus.enable = 1'b0; step(1);
        chk("t5_out_cleared", 32'(bus.coin_out[0]), 32'd0);
        chk("t5_busy_cleared", 32'(bus.busy[0]), 32'd0);
        step(5);
        bus.enable = 1'b1;
        any_hi = 1'b0;
        repeat (1000) begin step(1); if (bus.coin_out[0] === 1'b1) any_hi = 1'b1; end
        chk("t5_no_new_pulse", 32'(any_hi), 32'd0);
        chk("t5_total", 32'(bus.coin_total), 32'd1);
        bus.coin_raw[0] = 1'b0; step(40);

        // Reset during the gap
        do_reset();
        press(0, 40, 1);
        wait_level(0, 1'b1, 400, "t6_rise");
        run_len(0, 1'b1, 2000, n);
        step(50);
        reset = 1'b1; step(1);
        chk("t6_out", 32'(bus.coin_out), 32'd0);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        chk("t6_total", 32'(bus.coin_total), 32'd0);
        reset = 1'b0;
        press(0, 40, 1);
        wait_level(0, 1'b1, 400, "t6_rise2");
        run_len(0, 1'b1, 2000, n);
        chk("t6_high_cycles", 32'(n), 32'd300);
        chk("t6_total_after", 32'(bus.coin_total), 32'd1);

        // Random traffic with occasional disables and stalled frames
        do_reset();
        for (int c = 0; c < NCH; c++) hold_left[c] = 0;
        en_left = 0; vh_left = 0;
        for (int i = 0; i < 6000; i++) begin
            for (int c = 0; c < NCH; c++) begin
                if (hold_left[c] == 0) begin
                    bus.coin_raw[c] = ~bus.coin_raw[c];
                    hold_left[c] = int'($urandom_range(40, 1));
                end else begin
                    hold_left[c]--;
                end
            end
            if (en_left > 0) begin
                en_left--;
                if (en_left == 0) bus.enable = 1'b1;
            end else if ($urandom_range(799, 0) == 0) begin
                bus.enable = 1'b0; en_left = int'($urandom_range(30, 1));
            end
            if (vh_left > 0) begin
                vh_left--;
                if (vh_left == 0) vb_hold = 1'b0;
            end else if ($urandom_range(1499, 0) == 0) begin
                vb_hold = 1'b1; vh_left = int'($urandom_range(400, 50));
            end
            step(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
